// File: rtl/serial_cia_subtractor.sv
// Nibble-serial add/subtract unit: one 4-bit slice adder plus a carry register,
// one nibble per clock, valid/ready handshake on both sides.
module serial_cia_subtractor #(
  parameter  int WIDTH = 32,
  localparam int NIB   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_borrow,
  output logic             overflow
);

  localparam int SLICES = WIDTH / NIB;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int MSB    = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             op_q, op_d;
  logic             carry_q, carry_d;
  logic             cb_q, cb_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [NIB-1:0]   a_sl, b_sl, s;
  logic             c;
  logic             last;

  // The only adder in the unit: one nibble slice with carry-in from the register.
  always_comb begin
    a_sl   = a_q[cnt_q*NIB +: NIB];
    b_sl   = bx_q[cnt_q*NIB +: NIB];
    {c, s} = {1'b0, a_sl} + {1'b0, b_sl} + {{NIB{1'b0}}, carry_q};
    last   = (cnt_q == CW'(SLICES - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    bx_d    = bx_q;
    acc_d   = acc_q;
    res_d   = res_q;
    op_d    = op_q;
    carry_d = carry_q;
    cb_d    = cb_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          bx_d    = op_sub ? ~in_b : in_b;
          op_d    = op_sub;
          carry_d = op_sub;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[cnt_q*NIB +: NIB] = s;
        carry_d = c;
        cnt_d   = cnt_q + CW'(1);
        // Final slice lands in the result on the same edge it is computed.
        if (last) begin
          res_d   = acc_d;
          cb_d    = op_q ? ~c : c;
          ovf_d   = (a_q[MSB] == bx_q[MSB]) && (s[NIB-1] != a_q[MSB]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      bx_q    <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      cb_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cb_q    <= cb_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign result       = res_q;
  assign carry_borrow = cb_q;
  assign overflow     = ovf_q;

endmodule
